// File: rtl/vga_out_pipe_if.sv
// vga_out_pipe_if: pixel stream, frame controls and truncated colour output of the VGA output stage
interface vga_out_pipe_if #(
  parameter int IN_W = 8,
  parameter int OUT_W = 4
);
  logic vga_hsync_in, vga_vsync_in, vga_vde_in;
  logic [IN_W-1:0] vga_r_in, vga_g_in, vga_b_in;
  logic [1:0] mode_in;
  logic dither_en_in;
  logic [3*OUT_W-1:0] border_rgb_in;
  logic vga_hsync_out, vga_vsync_out;
  logic [OUT_W-1:0] vga_r_out, vga_g_out, vga_b_out;
  modport master (
    output vga_hsync_in, vga_vsync_in, vga_vde_in, vga_r_in, vga_g_in, vga_b_in,
    output mode_in, dither_en_in, border_rgb_in,
    input vga_hsync_out, vga_vsync_out, vga_r_out, vga_g_out, vga_b_out
  );
  modport slave (
    input vga_hsync_in, vga_vsync_in, vga_vde_in, vga_r_in, vga_g_in, vga_b_in,
    input mode_in, dither_en_in, border_rgb_in,
    output vga_hsync_out, vga_vsync_out, vga_r_out, vga_g_out, vga_b_out
  );
endinterface

// File: rtl/vga_out_pipe.sv
// vga_out_pipe: VGA output stage with test patterns, ordered dither and fixed-latency alignment
module vga_out_pipe #(
  parameter int IN_W = 8,
  parameter int OUT_W = 4,
  parameter int PIPE_STAGES = 2,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input logic clk_25,
  input logic reset_n,
  vga_out_pipe_if.slave vga
);
  localparam int SH = IN_W - OUT_W - 2;
  localparam int CW = 3 * OUT_W;
  localparam int OW = CW + 2;
  localparam logic [OW-1:0] RST_WORD = {~HSYNC_POL, ~VSYNC_POL, {CW{1'b0}}};
  logic [10:0] x_cnt;
  logic [9:0] y_cnt;
  logic frame, vs_d, vde_d;
  logic [1:0] sh_mode;
  logic sh_dith;
  logic [CW-1:0] sh_border;
  logic vs_rise, vde_fall, grid;
  logic [2:0] bar;
  logic [1:0] dith_b;
  logic [IN_W-1:0] pix [3];
  logic s1_hs, s1_vs, s1_vde, s1_dith;
  logic [1:0] s1_b;
  logic [CW-1:0] s1_border, s2_rgb;
  logic [OW-1:0] dly [PIPE_STAGES-1];
  always_comb begin
    vs_rise = vga.vga_vsync_in & ~vs_d;
    vde_fall = vde_d & ~vga.vga_vde_in;
    bar = x_cnt[9:7];
    grid = x_cnt[4:0] == 5'd0 || y_cnt[4:0] == 5'd0;
    dith_b = {x_cnt[0] ^ y_cnt[0], y_cnt[0]} ^ {2{frame}};
    pix[0] = vga.vga_r_in;
    pix[1] = vga.vga_g_in;
    pix[2] = vga.vga_b_in;
  end
  // frame-level controls only change on a vsync rising edge so a frame never mixes settings
  always_ff @(posedge clk_25 or negedge reset_n)
    if (!reset_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
      frame <= 1'b0;
      vs_d <= 1'b0;
      vde_d <= 1'b0;
      sh_mode <= '0;
      sh_dith <= 1'b0;
      sh_border <= '0;
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
      s1_vde <= 1'b0;
      s1_dith <= 1'b0;
      s1_b <= '0;
      s1_border <= '0;
    end else begin
      vs_d <= vga.vga_vsync_in;
      vde_d <= vga.vga_vde_in;
      x_cnt <= !vga.vga_vde_in ? '0 : &x_cnt ? x_cnt : x_cnt + 11'd1;
      y_cnt <= vs_rise ? '0 : vde_fall && !(&y_cnt) ? y_cnt + 10'd1 : y_cnt;
      frame <= frame ^ vs_rise;
      if (vs_rise) begin
        sh_mode <= vga.mode_in;
        sh_dith <= vga.dither_en_in;
        sh_border <= vga.border_rgb_in;
      end
      s1_hs <= vga.vga_hsync_in;
      s1_vs <= vga.vga_vsync_in;
      s1_vde <= vga.vga_vde_in;
      s1_dith <= sh_dith;
      s1_b <= dith_b;
      s1_border <= sh_border;
    end
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [IN_W-1:0] src, s1_c;
    logic [IN_W:0] sum;
    logic [OUT_W:0] hi;
    logic [OUT_W-1:0] bord, s1_bord, o;
    always_comb begin
      bord = sh_border[CW-1-c*OUT_W -: OUT_W];
      s1_bord = s1_border[CW-1-c*OUT_W -: OUT_W];
      src = sh_mode == 2'd0 ? pix[c] : sh_mode == 2'd1 ? {IN_W{bar[2-c]}} :
            sh_mode == 2'd2 ? {bord, {(IN_W-OUT_W){1'b0}}} : {IN_W{grid}};
      sum = {1'b0, s1_c} + (s1_dith ? {{(IN_W-1){1'b0}}, s1_b} << SH : '0);
      hi = (OUT_W+1)'(sum >> (IN_W - OUT_W));
      o = !s1_vde ? s1_bord : hi[OUT_W] ? '1 : hi[OUT_W-1:0];
    end
    always_ff @(posedge clk_25 or negedge reset_n)
      if (!reset_n) s1_c <= '0;
      else s1_c <= src;
  end
  assign s2_rgb = {g_ch[0].o, g_ch[1].o, g_ch[2].o};
  // extra stages beyond two are plain delay so every path keeps the same latency
  always_ff @(posedge clk_25 or negedge reset_n)
    if (!reset_n) begin
      for (int k = 0; k < PIPE_STAGES - 1; k++) dly[k] <= RST_WORD;
    end else begin
      dly[0] <= {s1_hs ^ ~HSYNC_POL, s1_vs ^ ~VSYNC_POL, s2_rgb};
      for (int k = 1; k < PIPE_STAGES - 1; k++) dly[k] <= dly[k-1];
    end
  assign {vga.vga_hsync_out, vga.vga_vsync_out, vga.vga_r_out, vga.vga_g_out, vga.vga_b_out} = dly[PIPE_STAGES-2];
endmodule

// File: tb/tb_vga_out_pipe.sv
// tb_vga_out_pipe: directed frames checked every cycle against a pixel-rule model, two latencies/polarities
module tb_vga_out_pipe;
  logic clk_25 = 1'b0, reset_n = 1'b1;
  always #5 clk_25 = ~clk_25;
  vga_out_pipe_if #(.IN_W(8), .OUT_W(4)) va ();
  vga_out_pipe_if #(.IN_W(8), .OUT_W(4)) vb ();
  vga_out_pipe #(.PIPE_STAGES(2)) dut (.clk_25(clk_25), .reset_n(reset_n), .vga(va.slave));
  vga_out_pipe #(.PIPE_STAGES(4), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) dut4 (
    .clk_25(clk_25), .reset_n(reset_n), .vga(vb.slave));
  assign vb.vga_hsync_in = va.vga_hsync_in;
  assign vb.vga_vsync_in = va.vga_vsync_in;
  assign vb.vga_vde_in = va.vga_vde_in;
  assign vb.vga_r_in = va.vga_r_in;
  assign vb.vga_g_in = va.vga_g_in;
  assign vb.vga_b_in = va.vga_b_in;
  assign vb.mode_in = va.mode_in;
  assign vb.dither_en_in = va.dither_en_in;
  assign vb.border_rgb_in = va.border_rgb_in;
  int mx, my, m_mode;
  bit mfr, mvs_d, mvde_d, m_dith;
  logic [11:0] m_bord;
  logic [13:0] hist [4];
  logic [13:0] row_w [2048];
  int n_chk = 0, n_err = 0;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  // expected word {hsync, vsync, r, g, b} with syncs active-high
  function automatic logic [13:0] model_word(input bit hs, vs, vde, input logic [7:0] r, g, b);
    int src, v, bs, bord;
    logic [3:0] o [3];
    logic [7:0] pin [3];
    pin = '{r, g, b};
    bs = ((mx % 2) ^ (my % 2)) * 2 + (my % 2);
    if (mfr) bs = bs ^ 3;
    for (int c = 0; c < 3; c++) begin
      bord = (m_bord >> (8 - 4 * c)) & 15;
      case (m_mode)
        0: src = pin[c];
        1: src = ((((mx / 128) % 8) >> (2 - c)) % 2 == 1) ? 255 : 0;
        2: src = bord * 16;
        default: src = (mx % 32 == 0 || my % 32 == 0) ? 255 : 0;
      endcase
      v = src + (m_dith ? bs * 4 : 0);
      if (v > 255) v = 255;
      o[c] = vde ? 4'(v / 16) : 4'(bord);
    end
    return {hs, vs, o[0], o[1], o[2]};
  endfunction
  task automatic px(input bit hs, vs, vde, input logic [7:0] r, g, b);
    logic [13:0] w;
    bit rise, fall;
    va.vga_hsync_in = hs;
    va.vga_vsync_in = vs;
    va.vga_vde_in = vde;
    va.vga_r_in = r;
    va.vga_g_in = g;
    va.vga_b_in = b;
    w = model_word(hs, vs, vde, r, g, b);
    if (vde) row_w[mx] = w;
    rise = vs && !mvs_d;
    fall = mvde_d && !vde;
    mx = vde ? (mx < 2047 ? mx + 1 : mx) : 0;
    my = rise ? 0 : (fall && my < 1023) ? my + 1 : my;
    if (rise) begin
      mfr = !mfr;
      m_mode = int'(va.mode_in);
      m_dith = va.dither_en_in;
      m_bord = va.border_rgb_in;
    end
    mvs_d = vs;
    mvde_d = vde;
    @(posedge clk_25);
    #1;
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = w;
  endtask
  task automatic model_reset();
    for (int k = 0; k < 4; k++) hist[k] = '0;
    mx = 0; my = 0; mfr = 0; mvs_d = 0; mvde_d = 0; m_mode = 0; m_dith = 0; m_bord = '0;
  endtask
  task automatic blank();
    px(0, 0, 0, 8'h11, 8'h22, 8'h33);
  endtask
  task automatic vsync();
    repeat (2) blank();
    repeat (3) px(0, 1, 0, 8'h44, 8'h55, 8'h66);
    repeat (2) blank();
  endtask
  task automatic line(input int n, input int hs_len, input int rc);
    repeat (2) blank();
    repeat (hs_len) px(1, 0, 0, 8'h11, 8'h22, 8'h33);
    repeat (2) blank();
    for (int x = 0; x < n; x++)
      if (rc >= 0) px(0, 0, 1, 8'(rc), 8'(rc), 8'(rc));
      else px(0, 0, 1, 8'(x * 7 - rc), 8'(x * 13 + 5), 8'(255 - x * 3 - rc));
  endtask
  always @(negedge clk_25) begin
    check("pipe2", {va.vga_hsync_out, va.vga_vsync_out, va.vga_r_out, va.vga_g_out, va.vga_b_out},
          {~hist[1][13], ~hist[1][12], hist[1][11:0]});
    check("pipe4", {vb.vga_hsync_out, vb.vga_vsync_out, vb.vga_r_out, vb.vga_g_out, vb.vga_b_out}, hist[3]);
  end
  initial begin
    model_reset();
    va.vga_hsync_in = 0; va.vga_vsync_in = 0; va.vga_vde_in = 0;
    va.vga_r_in = 0; va.vga_g_in = 0; va.vga_b_in = 0;
    va.mode_in = 2'd0; va.dither_en_in = 1'b0; va.border_rgb_in = 12'h123;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk_25);
    #1;
    check("rst_hsync_pol0", va.vga_hsync_out, 1'b1);
    check("rst_hsync_pol1", vb.vga_hsync_out, 1'b0);
    reset_n = 1'b1;
    vsync();
    line(40, 96, 'hA7);
    check("model_a7", row_w[0][11:0], 12'hAAA);
    blank();
    check("dut_a7_r", va.vga_r_out, 4'hA);
    blank();
    check("dut_border", {va.vga_r_out, va.vga_g_out, va.vga_b_out}, 12'h123);
    line(50, 4, -3);
    line(50, 4, -9);
    line(20, 4, -5);
    va.mode_in = 2'd1;
    line(300, 4, -5);
    vsync();
    line(300, 4, -1);
    check("bars_130", row_w[130][11:0], 12'h00F);
    check("bars_255", row_w[255][11:0], 12'h00F);
    check("bars_127", row_w[127][11:0], 12'h000);
    check("bars_256", row_w[256][11:0], 12'h0F0);
    va.mode_in = 2'd0;
    va.dither_en_in = 1'b1;
    line(10, 4, 8);
    vsync();
    line(20, 4, 8);
    check("dith_f1_x0", row_w[0][11:8], 4'h1);
    check("dith_f1_x1", row_w[1][11:8], 4'h0);
    line(20, 4, 255);
    check("dith_sat", row_w[5][11:0], 12'hFFF);
    line(60, 4, -7);
    vsync();
    line(20, 4, 8);
    check("dith_f0_x0", row_w[0][11:8], 4'h0);
    check("dith_f0_x1", row_w[1][11:8], 4'h1);
    va.mode_in = 2'd3;
    va.dither_en_in = 1'b0;
    vsync();
    for (int l = 0; l < 65; l++) begin
      line(40, 2, -2);
      if (l == 5) begin
        check("grid_32_5", row_w[32][11:0], 12'hFFF);
        check("grid_7_5", row_w[7][11:0], 12'h000);
      end
      if (l == 64) check("grid_7_64", row_w[7][11:0], 12'hFFF);
    end
    va.mode_in = 2'd2;
    va.border_rgb_in = 12'hA5C;
    vsync();
    line(30, 4, -4);
    check("solid_border", row_w[3][11:0], 12'hA5C);
    va.mode_in = 2'd0;
    repeat (2) blank();
    for (int x = 0; x < 10; x++) px(0, 0, 1, 8'(x * 20), 8'h80, 8'h40);
    reset_n = 1'b0;
    #1;
    check("rst_now_p2", {va.vga_hsync_out, va.vga_vsync_out, va.vga_r_out, va.vga_g_out, va.vga_b_out}, 14'h3000);
    check("rst_now_p4", {vb.vga_hsync_out, vb.vga_vsync_out, vb.vga_r_out, vb.vga_g_out, vb.vga_b_out}, 14'h0000);
    model_reset();
    repeat (3) @(posedge clk_25);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      px(0, 0, 1, 8'hF0, 8'hF0, 8'hF0);
      check("fill_p4", {vb.vga_r_out, vb.vga_g_out, vb.vga_b_out}, 12'h000);
    end
    px(0, 0, 1, 8'hF0, 8'hF0, 8'hF0);
    check("first_p4", {vb.vga_r_out, vb.vga_g_out, vb.vga_b_out}, 12'hFFF);
    repeat (8) px(0, 0, 1, 8'h37, 8'hC9, 8'h5E);
    repeat (6) blank();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
